// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the FIFO register file: write pointer, occupancy count, fill FSM, row strobes.
// Optional almost-full flag enabled by defining FIFO_WR_AFULL_EN.
module fifo_wr_ctrl #(
  parameter int unsigned AW       = 3,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic                  i_rd_adv,
  output logic [(2**AW)-1:0]    o_to_reg,
  output logic [AW-1:0]         o_wr_addr,
  output logic [AW:0]           o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_wr_err
`ifdef FIFO_WR_AFULL_EN
  ,
  output logic                  o_afull
`endif
);

  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_wr_addr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_wr_err;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flags come from the registered state, so accepts never see this cycle's rd_adv.
  assign w_full   = (r_state == S_FULL);
  assign w_empty  = (r_state == S_EMPTY);
  assign w_wr_acc = i_we & ~w_full & ~i_reset;
  assign w_rd_acc = i_rd_adv & ~w_empty & ~i_reset;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Fill FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_wr_acc) w_state_nxt = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (w_count_nxt == CW'(DEPTH))  w_state_nxt = S_FULL;
        else if (w_count_nxt == '0)     w_state_nxt = S_EMPTY;
      end
      S_FULL: begin
        if (w_rd_acc) w_state_nxt = S_PARTIAL;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_EMPTY;
      r_wr_addr <= '0;
      r_count   <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_wr_err  <= i_we & w_full;
      if (w_wr_acc) r_wr_addr <= r_wr_addr + AW'(1);
    end
  end

  // Zero-latency strobe: row is written on the edge the pointer advances.
  assign o_to_reg  = w_wr_acc ? (DEPTH'(1) << r_wr_addr) : '0;
  assign o_wr_addr = r_wr_addr;
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_wr_err  = r_wr_err;

`ifdef FIFO_WR_AFULL_EN
  logic r_afull;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_afull <= 1'b0;
    else         r_afull <= (w_count_nxt >= CW'(AF_LEVEL));
  end

  assign o_afull = r_afull;
`else
  logic w_unused_af;
  assign w_unused_af = |AF_LEVEL;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl (AW=3): stimulus pushes expectations, a negedge monitor pops and checks.
module tb_fifo_wr_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFL   = 6;

  logic             clk;
  logic             reset;
  logic             we;
  logic             rd_adv;
  logic [DEPTH-1:0] to_reg;
  logic [AW-1:0]    wr_addr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             wr_err;
`ifdef FIFO_WR_AFULL_EN
  logic             afull;
`endif

  fifo_wr_ctrl #(.AW(AW), .AF_LEVEL(AFL)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_we      (we),
    .i_rd_adv  (rd_adv),
    .o_to_reg  (to_reg),
    .o_wr_addr (wr_addr),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty),
    .o_wr_err  (wr_err)
`ifdef FIFO_WR_AFULL_EN
    ,
    .o_afull   (afull)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int to_reg;
    int wr_addr;
    int count;
    int full;
    int empty;
    int wr_err;
    int afull;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state (reset state, since reset is held over the first edge)
  int m_cnt = 0;
  int m_ptr = 0;
  int m_err = 0;
  int m_af  = 0;
  int vec   = 0;

  task automatic check(input string name, input int tag, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, tag, act, req);
    end
  endtask

  // Drive one cycle of inputs, record what the DUT must show during it, then step the model.
  task automatic cyc(input int r, input int w, input int rd);
    exp_t e;
    int wa, ra;
    @(posedge clk);
    #1;
    reset  = r[0];
    we     = w[0];
    rd_adv = rd[0];
    wa = (r == 0 && w != 0 && m_cnt < DEPTH) ? 1 : 0;
    ra = (r == 0 && rd != 0 && m_cnt > 0) ? 1 : 0;
    e.tag     = vec;
    e.to_reg  = wa ? (1 << m_ptr) : 0;
    e.wr_addr = m_ptr;
    e.count   = m_cnt;
    e.full    = (m_cnt == DEPTH) ? 1 : 0;
    e.empty   = (m_cnt == 0) ? 1 : 0;
    e.wr_err  = m_err;
    e.afull   = m_af;
    q.push_back(e);
    vec++;
    if (r != 0) begin
      m_cnt = 0; m_ptr = 0; m_err = 0; m_af = 0;
    end else begin
      m_err = (w != 0 && m_cnt == DEPTH) ? 1 : 0;
      m_ptr = (m_ptr + wa) % DEPTH;
      m_cnt = m_cnt + wa - ra;
      m_af  = (m_cnt >= AFL) ? 1 : 0;
    end
  endtask

  task automatic repeat_cyc(input int n, input int r, input int w, input int rd);
    for (int i = 0; i < n; i++) cyc(r, w, rd);
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("to_reg",  e.tag, int'(to_reg),  e.to_reg);
      check("wr_addr", e.tag, int'(wr_addr), e.wr_addr);
      check("count",   e.tag, int'(count),   e.count);
      check("full",    e.tag, int'(full),    e.full);
      check("empty",   e.tag, int'(empty),   e.empty);
      check("wr_err",  e.tag, int'(wr_err),  e.wr_err);
`ifdef FIFO_WR_AFULL_EN
      check("afull",   e.tag, int'(afull),   e.afull);
`endif
    end
  end

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    rd_adv = 1'b0;
    repeat_cyc(2, 1, 0, 0);   // reset state
    repeat_cyc(8, 0, 1, 0);   // fill: strobes 0x01..0x80, count 1..8
    repeat_cyc(2, 0, 1, 0);   // rejected writes while full, wr_err continuous
    cyc(0, 0, 0);
    cyc(0, 1, 1);             // write rejected, read accepted -> 7
    cyc(0, 1, 0);             // strobe 0x01, back to 8
    cyc(0, 0, 0);
    repeat_cyc(5, 0, 0, 1);   // drain to 3
    repeat_cyc(10, 0, 1, 1);  // steady count 3, pointer wraps
    repeat_cyc(3, 0, 0, 1);   // drain to 0
    repeat_cyc(3, 0, 0, 1);   // reads while empty ignored
    repeat_cyc(6, 0, 1, 0);   // up to 6 (afull rises)
    cyc(0, 0, 1);             // 5 (afull falls)
    cyc(1, 1, 0);             // reset with write request: no strobe
    repeat_cyc(2, 0, 0, 0);
    cyc(0, 1, 0);             // first write after reset hits row 0
    cyc(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", vec, q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
